// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter for the ena/si link.
// Each frame is the DSIZE-bit header DTECT, then the DSIZE-bit payload (both
// MSB first), then an optional even-parity bit, then GAP_CYC idle cycles with
// ena low so the receiver shift register clears between frames.
module seq_tx #(
  parameter int DSIZE   = 8,
  parameter int DTECT   = 85,
  parameter int PAR_EN  = 1,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             ena,
  output logic             si,
  output logic             busy,
  output logic             tx_done,
  output logic [15:0]      frame_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam int BW = (DSIZE > 2) ? $clog2(DSIZE) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DSIZE-1:0] HDR      = DSIZE'(DTECT);
  localparam logic [BW-1:0]    BIT_LAST = BW'(DSIZE - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]    bit_nxt;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DSIZE-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             ena_q, ena_d;
  logic             si_q, si_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  assign in_ready  = (state_q == S_IDLE);
  assign ena       = ena_q;
  assign si        = si_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign frame_cnt = frame_cnt_q;

  // Next-state and next-output decode; ena/si are computed for the state being
  // entered so the registered outputs line up with the state register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    ena_d       = 1'b0;
    si_d        = 1'b0;
    tx_done_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    bit_nxt     = bit_cnt_q - BW'(1);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_HEAD;
          shreg_d   = in_data;
          par_d     = ^in_data;
          bit_cnt_d = BIT_LAST;
          ena_d     = 1'b1;
          si_d      = HDR[DSIZE-1];
        end
      end
      S_HEAD: begin
        ena_d = 1'b1;
        if (bit_cnt_q == '0) begin
          state_d   = S_DATA;
          bit_cnt_d = BIT_LAST;
          si_d      = shreg_q[DSIZE-1];
        end else begin
          bit_cnt_d = bit_nxt;
          si_d      = HDR[bit_nxt];
        end
      end
      S_DATA: begin
        if (bit_cnt_q == '0) begin
          if (PAR_EN != 0) begin
            state_d = S_PAR;
            ena_d   = 1'b1;
            si_d    = par_q;
          end else begin
            state_d     = S_GAP;
            gap_cnt_d   = GAP_LAST;
            tx_done_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else begin
          ena_d     = 1'b1;
          bit_cnt_d = bit_nxt;
          si_d      = shreg_q[bit_nxt];
        end
      end
      S_PAR: begin
        state_d     = S_GAP;
        gap_cnt_d   = GAP_LAST;
        tx_done_d   = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      ena_q       <= 1'b0;
      si_q        <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      ena_q       <= ena_d;
      si_q        <= si_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed bench for seq_tx. Instance a uses default parameters,
// instance b has no parity and a one-cycle gap. A reference receiver per
// instance shifts si in while ena is high and clears while ena is low.
module tb_seq_tx;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_ena, a_si, a_busy, a_tx_done;
  logic [7:0]  a_in_data;
  logic [15:0] a_frame_cnt;

  logic        b_in_valid, b_in_ready, b_ena, b_si, b_busy, b_tx_done;
  logic [7:0]  b_in_data;
  logic [15:0] b_frame_cnt;

  logic [7:0]  rx_a, rx_b;
  logic        match_a, match_b;
  int          done_a, done_b;

  int n_checks;
  int n_errors;

  seq_tx #(.DSIZE(8), .DTECT(85), .PAR_EN(1), .GAP_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .ena(a_ena), .si(a_si), .busy(a_busy),
    .tx_done(a_tx_done), .frame_cnt(a_frame_cnt)
  );

  seq_tx #(.DSIZE(8), .DTECT(85), .PAR_EN(0), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .ena(b_ena), .si(b_si), .busy(b_busy),
    .tx_done(b_tx_done), .frame_cnt(b_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference receivers and tx_done pulse counters.
  always @(posedge clk) begin
    rx_a   <= a_ena ? {rx_a[6:0], a_si} : 8'h00;
    rx_b   <= b_ena ? {rx_b[6:0], b_si} : 8'h00;
    done_a <= done_a + (a_tx_done ? 1 : 0);
    done_b <= done_b + (b_tx_done ? 1 : 0);
  end
  assign match_a = (rx_a == 8'h55);
  assign match_b = (rx_b == 8'h55);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  function automatic logic ena_of(input int which);
    return (which == 0) ? a_ena : b_ena;
  endfunction

  function automatic logic si_of(input int which);
    return (which == 0) ? a_si : b_si;
  endfunction

  function automatic logic match_of(input int which);
    return (which == 0) ? match_a : match_b;
  endfunction

  // One-cycle in_valid pulse; caller ensures the instance is idle.
  task automatic send(input int which, input logic [7:0] d);
    if (which == 0) begin
      a_in_data = d; a_in_valid = 1'b1; tick; a_in_valid = 1'b0;
    end else begin
      b_in_data = d; b_in_valid = 1'b1; tick; b_in_valid = 1'b0;
    end
  endtask

  // Collects si while ena is high (bounded); m8 is the receiver flag after 8 bits.
  task automatic collect(input int which, output int len, output logic [31:0] bits,
                         output logic m8);
    len  = 0;
    bits = '0;
    m8   = 1'b0;
    while (ena_of(which) && len < 40) begin
      bits = {bits[30:0], si_of(which)};
      if (len == 8) m8 = match_of(which);
      len++;
      tick;
    end
  endtask

  initial begin
    int          len;
    logic [31:0] bits;
    logic        m8;
    int          rise [3];
    logic        par [3];
    int          k, run, rdy_cnt, ena_hi, snap;
    logic        prev_ena;

    n_checks = 0;
    n_errors = 0;
    done_a = 0; done_b = 0;
    rx_a = '0; rx_b = '0;
    a_in_valid = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_data = '0;
    rst = 1'b0;
    #2;
    do_reset;

    // Reset state.
    check("rst_in_ready", a_in_ready, 1);
    check("rst_ena", a_ena, 0);
    check("rst_si", a_si, 0);
    check("rst_busy", a_busy, 0);
    check("rst_tx_done", a_tx_done, 0);
    check("rst_frame_cnt", a_frame_cnt, 0);
    check("rst_b_in_ready", b_in_ready, 1);

    // Single frame with A3.
    send(0, 8'hA3);
    check("t1_busy", a_busy, 1);
    check("t1_in_ready", a_in_ready, 0);
    check("t1_first_si", a_si, 0);
    collect(0, len, bits, m8);
    check("t1_ena_len", len, 17);
    check("t1_bits", bits, 32'h0000AB46);
    check("t1_hdr_match", m8, 1);
    check("t1_tx_done", a_tx_done, 1);
    check("t1_frame_cnt", a_frame_cnt, 1);
    tick;
    check("t1_tx_done_once", a_tx_done, 0);
    check("t1_gap2_ready", a_in_ready, 0);
    tick;
    check("t1_idle_ready", a_in_ready, 1);
    check("t1_done_count", done_a, 1);

    // No parity, one gap cycle, payload equal to the header.
    send(1, 8'h55);
    collect(1, len, bits, m8);
    check("t3_ena_len", len, 16);
    check("t3_bits", bits, 32'h00005555);
    check("t3_hdr_match", m8, 1);
    check("t3_pay_match", match_b, 1);
    check("t3_tx_done", b_tx_done, 1);
    check("t3_gap_ready", b_in_ready, 0);
    check("t3_frame_cnt", b_frame_cnt, 1);
    tick;
    check("t3_idle_ready", b_in_ready, 1);
    check("t3_idle_ena", b_ena, 0);

    // Back-to-back frames with in_valid held high.
    do_reset;
    k = 0; run = 0; rdy_cnt = 0; prev_ena = 1'b0;
    rise[0] = 0; rise[1] = 0; rise[2] = 0;
    par[0] = 1'bx; par[1] = 1'bx; par[2] = 1'bx;
    a_in_data = 8'hFF;
    a_in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (a_ena && !prev_ena && k < 3) begin
        rise[k] = c;
        k++;
        if (k == 1) a_in_data = 8'h01;
        if (k == 2) a_in_data = 8'h80;
        if (k == 3) a_in_valid = 1'b0;
      end
      run = a_ena ? run + 1 : 0;
      if (run == 17 && k > 0) par[k-1] = a_si;
      if (k >= 1 && k < 3 && a_in_ready) rdy_cnt++;
      if (k == 3 && !a_busy) break;
      prev_ena = a_ena;
      tick;
    end
    check("t2_frames", k, 3);
    check("t2_period_1", rise[1] - rise[0], 20);
    check("t2_period_2", rise[2] - rise[1], 20);
    check("t2_par_ff", par[0], 0);
    check("t2_par_01", par[1], 1);
    check("t2_par_80", par[2], 1);
    check("t2_ready_cycles", rdy_cnt, 2);
    check("t2_frame_cnt", a_frame_cnt, 3);

    // Reset during the 5th payload bit.
    do_reset;
    snap = done_a;
    send(0, 8'h77);
    for (int i = 0; i < 12; i++) tick;
    check("t4_pre_ena", a_ena, 1);
    rst = 1'b1;
    #1;
    check("t4_ena", a_ena, 0);
    check("t4_si", a_si, 0);
    check("t4_busy", a_busy, 0);
    check("t4_in_ready", a_in_ready, 1);
    check("t4_frame_cnt", a_frame_cnt, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    tick;
    check("t4_no_done", done_a, snap);
    check("t4_cnt_after", a_frame_cnt, 0);
    send(0, 8'h3C);
    collect(0, len, bits, m8);
    check("t4_len", len, 17);
    check("t4_bits", bits, 32'h0000AA78);
    check("t4_frame_cnt_new", a_frame_cnt, 1);
    tick;
    tick;

    // in_valid pulses during HEAD and GAP are ignored; payload 0.
    snap = done_a;
    send(0, 8'h00);
    bits = '0;
    len  = 0;
    for (int i = 0; i < 17; i++) begin
      if (a_ena) len++;
      bits = {bits[30:0], a_si};
      if (i == 3) begin a_in_data = 8'hFF; a_in_valid = 1'b1; end
      if (i == 4) a_in_valid = 1'b0;
      tick;
    end
    check("t5_len", len, 17);
    check("t5_bits", bits, 32'h0000AA00);
    check("t5_gap_done", a_tx_done, 1);
    a_in_valid = 1'b1;
    tick;
    a_in_valid = 1'b0;
    tick;
    check("t5_idle_ready", a_in_ready, 1);
    ena_hi = 0;
    for (int i = 0; i < 25; i++) begin
      if (a_ena) ena_hi++;
      tick;
    end
    check("t5_no_extra", ena_hi, 0);
    check("t5_frame_cnt", a_frame_cnt, 2);
    check("t5_done_count", done_a - snap, 1);

    // frame_cnt wrap.
    force dut_a.frame_cnt_q = 16'hFFFF;
    tick;
    release dut_a.frame_cnt_q;
    tick;
    check("t6_preload", a_frame_cnt, 16'hFFFF);
    send(0, 8'h5A);
    collect(0, len, bits, m8);
    check("t6_tx_done", a_tx_done, 1);
    check("t6_wrap", a_frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
- Serial frame transmitter. It is the sending end of the ena/si serial link whose receiver shifts si in MSB-first while ena is high, and flags when the shift register equals the DTECT header.
- Accepts a parallel payload word over a valid/ready handshake and emits one frame on ena/si: DSIZE-bit header DTECT, then the DSIZE-bit payload, then an optional even-parity bit, then an idle gap with ena low.
- The gap clears the receiver shift register between frames.

Parameters:
- DSIZE, 8, header and payload width in bits (legal: 2 or more).
- DTECT, 85, header pattern (8'h55 at default). Only the low DSIZE bits are used.
- PAR_EN, 1, 1 appends an even-parity bit over the payload; 0 omits it.
- GAP_CYC, 2, number of ena-low cycles after each frame (legal: 1 or more).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  payload word offered.
- in_data  input  DSIZE  payload word, sampled on handshake.
- in_ready  output  1  block can accept a word.
- ena  output  1  serial enable; high for header, payload and parity bits.
- si  output  1  serial data, MSB first.
- busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse on the first GAP cycle.
- frame_cnt  output  16  frames completed; wraps 16'hFFFF -> 0.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is asynchronous and active-high.
  - Asserting rst at any time forces state IDLE immediately: ena=0, si=0, busy=0, tx_done=0, frame_cnt=0, in_ready=1. This holds mid-frame; the partial frame is dropped and the held payload is discarded.
- All outputs are registered except in_ready, which is decoded from the state register (in_ready = state==IDLE).
- States: IDLE, HEAD, DATA, PAR, GAP.
- IDLE:
  - ena=0, si=0.
  - When in_valid && in_ready at edge T: latch in_data into a shift register, load the bit counter with DSIZE-1, go to HEAD.
  - From cycle T+1: ena=1, si=DTECT[DSIZE-1].
- HEAD:
  - Drives DTECT MSB first, one bit per cycle, for DSIZE cycles.
  - After the last header bit, go to DATA.
- DATA:
  - Drives the payload MSB first for DSIZE cycles.
  - Go to PAR if PAR_EN=1, otherwise to GAP.
- PAR:
  - One cycle, si = XOR of all payload bits (even parity), ena=1.
  - Go to GAP.
- GAP:
  - ena=0, si=0 for GAP_CYC cycles.
  - tx_done=1 and frame_cnt increments on the first GAP cycle only.
  - Then go to IDLE.
- Receiver alignment:
  - On the cycle after the last header bit, a receiver clocked on the same edge holds exactly DTECT, so its match flag is high during the first DATA bit.
  - Payload bits may alias DTECT inside the receiver's window; higher layers own that. This block does not scramble.
- Handshake:
  - in_valid is ignored outside IDLE; in_data need not be held after the accepting edge.
  - in_valid held high gives back-to-back frames with period 1 + 2*DSIZE + PAR_EN + GAP_CYC cycles (20 at defaults).
- Counters:
  - Bit counter is sized to log2 of DSIZE.
  - The gap counter is separate and sized for GAP_CYC.
  - No overflow is possible other than the intended frame_cnt wrap.
- Payload 0: all DATA bits 0, parity 0.

Test Plan:
- Reset, then in_data=8'hA3 with a one-cycle in_valid. Required:
  - ena high for exactly 17 cycles.
  - si sequence 01010101 10100011 0 (parity of A3 is 0).
  - tx_done pulses once; frame_cnt=1.
  - A reference receiver model flags a match on the cycle after the 8th header bit.
- in_valid held high with data 8'hFF, 8'h01, 8'h80. Required:
  - Frames start 20 cycles apart.
  - Parity bits are 0, 1, 1.
  - in_ready is high only in the single IDLE cycle between frames.
  - frame_cnt=3.
- PAR_EN=0, GAP_CYC=1, in_data=8'h55. Required:
  - 16 ena-high cycles, then exactly 1 ena-low cycle before in_ready rises.
  - The reference receiver flags a match twice: after header and after payload.
- Assert rst during the 5th DATA bit. Required:
  - ena=0 and si=0 in the same cycle.
  - frame_cnt stays 0, no tx_done pulse.
  - After release, a new frame with 8'h3C transmits correctly.
- in_valid pulsed during HEAD and during GAP. Required: both pulses ignored, no extra frame, frame_cnt increments by 1 only.
- Preload frame_cnt to 16'hFFFF via 65535 frames (or force), then send one more frame. Required: frame_cnt reads 0 after that frame's tx_done.
